// File: rtl/sd_pkg.sv
// ----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD-bus command-line controller and the 4-bit DAT
// reader that follows it.
//
// Contents:
//   - CRC7 generator polynomial.
//   - 48-bit command/response frame length and field offsets.
//   - o_status bit positions.
//   - Default NCR (response wait) and NCC (inter-command gap) values.
//   - Controller state encoding.
//   - A helper that assembles a command frame with an empty CRC field.
// ----------------------------------------------------------------------------
package sd_pkg;

   // x^7 + x^3 + 1, x^7 term implicit
   localparam logic [6:0] CRC7_POLY = 7'h09;

   localparam int FRAME_LEN = 48;
   // The CRC covers start bit, transmission bit, index and argument
   localparam int CRC_BITS  = 40;

   // Field offsets within a 48-bit frame (bit 47 is sent first)
   localparam int IDX_MSB = 45;
   localparam int IDX_LSB = 40;
   localparam int ARG_MSB = 39;
   localparam int ARG_LSB = 8;
   localparam int CRC_MSB = 7;
   localparam int CRC_LSB = 1;

   // o_status bit positions
   localparam int ST_TIMEOUT = 0;
   localparam int ST_CRC_ERR = 1;
   localparam int ST_END_ERR = 2;

   // Bus timing defaults, also used by the DAT reader
   localparam int NCR_DEFAULT = 64;
   localparam int NCC_DEFAULT = 8;

   typedef enum logic [2:0] {
      CMD_IDLE,
      CMD_SEND,
      CMD_TURN,
      CMD_RECV,
      CMD_GAP
   } cmd_state_t;

   // Start 0, transmission 1, index, argument, zeroed CRC field, end bit 1.
   // The CRC field is filled in on the fly while the frame is shifted out.
   function automatic logic [FRAME_LEN-1:0] cmd_frame(input logic [5:0]  idx,
                                                      input logic [31:0] arg);
      return {1'b0, 1'b1, idx, arg, 7'h00, 1'b1};
   endfunction

endpackage

// File: rtl/sd_cmd_ctrl_if.sv
// ----------------------------------------------------------------------------
// sd_cmd_ctrl_if
// Bundles the request, CMD-line, reader-start and completion signals of the
// SD command controller.
//
// Modports:
//   master - the host/card side: drives the request and the sampled CMD line,
//            observes the CMD drive, completion and response fields.
//   slave  - the controller itself.
//
// Signals:
//   i_cmd_start   request strobe
//   i_cmd_index   command index (6)
//   i_cmd_arg     command argument (32)
//   i_resp_en     a 48-bit response is expected
//   i_crc_chk     check the response CRC7
//   i_data_exp    the command opens a DAT read phase
//   i_cmd_in      sampled CMD line
//   o_cmd_out     CMD line drive value
//   o_cmd_oe      CMD line output enable
//   o_rd_start    start pulse for the DAT reader
//   o_busy        controller busy, including the NCC gap
//   o_done        completion pulse
//   o_resp_index  response index field (6)
//   o_resp_arg    response bits 39..8 (32)
//   o_status      [0] timeout, [1] CRC error, [2] end-bit error
// ----------------------------------------------------------------------------
interface sd_cmd_ctrl_if;

   logic        i_cmd_start;
   logic [5:0]  i_cmd_index;
   logic [31:0] i_cmd_arg;
   logic        i_resp_en;
   logic        i_crc_chk;
   logic        i_data_exp;
   logic        i_cmd_in;
   logic        o_cmd_out;
   logic        o_cmd_oe;
   logic        o_rd_start;
   logic        o_busy;
   logic        o_done;
   logic [5:0]  o_resp_index;
   logic [31:0] o_resp_arg;
   logic [2:0]  o_status;

   modport master (
      output i_cmd_start, i_cmd_index, i_cmd_arg, i_resp_en, i_crc_chk,
             i_data_exp, i_cmd_in,
      input  o_cmd_out, o_cmd_oe, o_rd_start, o_busy, o_done,
             o_resp_index, o_resp_arg, o_status
   );

   modport slave (
      input  i_cmd_start, i_cmd_index, i_cmd_arg, i_resp_en, i_crc_chk,
             i_data_exp, i_cmd_in,
      output o_cmd_out, o_cmd_oe, o_rd_start, o_busy, o_done,
             o_resp_index, o_resp_arg, o_status
   );

endinterface

// File: rtl/sd_crc7.sv
// ----------------------------------------------------------------------------
// sd_crc7
// Serial CRC7 (x^7 + x^3 + 1, initial value 0), one bit per clock.
//
// Ports:
//   clk     clock
//   clr     synchronous clear to 0, takes priority over en
//   en      shift bit_in into the CRC this cycle
//   bit_in  serial data bit, MSB of the message first
//   crc     current CRC remainder
// ----------------------------------------------------------------------------
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   logic fb;

   assign fb = bit_in ^ crc[6];

   always_ff @(posedge clk) begin
      if (clr) begin
         crc <= '0;
      end else if (en) begin
         crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
      end
   end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// sd_cmd_ctrl
// SD-bus CMD-line controller. Sends one 48-bit command MSB first with its
// CRC7, optionally waits for and captures a 48-bit short response, and pulses
// the DAT reader's start input when the command opens a read data phase.
// One CMD bit is driven or sampled per clk cycle.
//
// Parameters:
//   RESP_TIMEOUT  cycles to wait for the response start bit (NCR)
//   NCC           idle cycles between o_done and the next accepted command
//
// Ports:
//   clk  card clock, CMD driven and sampled on the rising edge
//   rst  synchronous, active-high reset
//   bus  sd_cmd_ctrl_if.slave: request, CMD line, reader start, results
// ----------------------------------------------------------------------------
module sd_cmd_ctrl
   import sd_pkg::*;
#(
   parameter int RESP_TIMEOUT = NCR_DEFAULT,
   parameter int NCC          = NCC_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   sd_cmd_ctrl_if.slave bus
);

   // One timer serves both the response wait and the NCC gap
   localparam int TMR_MAX = (RESP_TIMEOUT > NCC) ? RESP_TIMEOUT : NCC;
   localparam int TW      = $clog2(TMR_MAX + 1);

   localparam logic [5:0] TX_LAST    = 6'(FRAME_LEN - 1);   // end bit slot
   localparam logic [5:0] TX_CRC_POS = 6'(CRC_BITS);        // first CRC bit slot
   localparam logic [5:0] RX_LAST    = 6'(FRAME_LEN - 2);   // bit 0 after start
   localparam logic [5:0] RX_CRC_END = 6'(CRC_BITS - 1);    // bits 46..8 feed CRC

   cmd_state_t        state_q, state_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [47:0]       tx_sr_q, tx_sr_d;
   logic [44:0]       rx_sr_q, rx_sr_d;
   logic              resp_en_q, resp_en_d;
   logic              crc_chk_q, crc_chk_d;
   logic              data_exp_q, data_exp_d;
   logic              done_q, done_d;
   logic              rd_start_q, rd_start_d;
   logic [2:0]        status_q, status_d;
   logic [5:0]        resp_idx_q, resp_idx_d;
   logic [31:0]       resp_arg_q, resp_arg_d;

   logic              cmd_out;
   logic              cmd_oe;
   logic              crc_clr;
   logic              crc_en;
   logic              crc_bit;
   logic [6:0]        crc_val;
   logic [2:0]        crc_sel;
   logic [45:0]       rx_full;

   // The CRC engine is shared: TX and RX phases never overlap
   sd_crc7 u_crc (
      .clk    (clk),
      .clr    (crc_clr | rst),
      .en     (crc_en),
      .bit_in (crc_bit),
      .crc    (crc_val)
   );

   // CRC slots 40..46 carry crc[6]..crc[0]
   assign crc_sel = 3'(6'd46 - cnt_q);

   // Response bits 45..0 once the final bit is on the line; the start and
   // transmission bits have already been shifted out of rx_sr_q
   assign rx_full = {rx_sr_q, bus.i_cmd_in};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmr_d      = tmr_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      resp_en_d  = resp_en_q;
      crc_chk_d  = crc_chk_q;
      data_exp_d = data_exp_q;
      done_d     = 1'b0;
      rd_start_d = 1'b0;
      status_d   = status_q;
      resp_idx_d = resp_idx_q;
      resp_arg_d = resp_arg_q;
      cmd_out    = 1'b1;
      cmd_oe     = 1'b0;
      crc_clr    = 1'b0;
      crc_en     = 1'b0;
      crc_bit    = 1'b0;

      case (state_q)
         CMD_IDLE: begin
            if (bus.i_cmd_start) begin
               tx_sr_d    = cmd_frame(bus.i_cmd_index, bus.i_cmd_arg);
               resp_en_d  = bus.i_resp_en;
               crc_chk_d  = bus.i_crc_chk;
               data_exp_d = bus.i_data_exp;
               status_d   = '0;
               cnt_d      = '0;
               crc_clr    = 1'b1;
               state_d    = CMD_SEND;
            end
         end

         CMD_SEND: begin
            cmd_oe = 1'b1;
            if (cnt_q >= TX_CRC_POS && cnt_q < TX_LAST) begin
               cmd_out = crc_val[crc_sel];
            end else begin
               cmd_out = tx_sr_q[47];
            end
            if (cnt_q < TX_CRC_POS) begin
               crc_en  = 1'b1;
               crc_bit = tx_sr_q[47];
            end
            tx_sr_d = {tx_sr_q[46:0], 1'b1};
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q == TX_LAST) begin
               rd_start_d = data_exp_q;
               cnt_d      = '0;
               tmr_d      = '0;
               if (!resp_en_q) begin
                  done_d  = 1'b1;
                  state_d = CMD_GAP;
               end else begin
                  state_d = CMD_TURN;
               end
            end
         end

         CMD_TURN: begin
            // A start bit on the last allowed cycle still wins over timeout
            if (!bus.i_cmd_in) begin
               // Start bit is 0 and leaves a zero CRC unchanged, so a clear
               // here is the same as feeding it
               crc_clr = 1'b1;
               cnt_d   = '0;
               state_d = CMD_RECV;
            end else if (tmr_q == TW'(RESP_TIMEOUT - 1)) begin
               status_d[ST_TIMEOUT] = 1'b1;
               done_d               = 1'b1;
               tmr_d                = '0;
               state_d              = CMD_GAP;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         CMD_RECV: begin
            rx_sr_d = {rx_sr_q[43:0], bus.i_cmd_in};
            cnt_d   = cnt_q + 6'd1;
            if (cnt_q < RX_CRC_END) begin
               crc_en  = 1'b1;
               crc_bit = bus.i_cmd_in;
            end
            if (cnt_q == RX_LAST) begin
               status_d[ST_CRC_ERR] = crc_chk_q &&
                                      (crc_val != rx_full[CRC_MSB:CRC_LSB]);
               status_d[ST_END_ERR] = !bus.i_cmd_in;
               resp_idx_d           = rx_full[IDX_MSB:IDX_LSB];
               resp_arg_d           = rx_full[ARG_MSB:ARG_LSB];
               done_d               = 1'b1;
               tmr_d                = '0;
               state_d              = CMD_GAP;
            end
         end

         CMD_GAP: begin
            if (tmr_q == TW'(NCC - 1)) begin
               state_d = CMD_IDLE;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         default: begin
            state_d = CMD_IDLE;
         end
      endcase
   end

   // State, counters, pulses and visible results
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CMD_IDLE;
         cnt_q      <= '0;
         tmr_q      <= '0;
         done_q     <= 1'b0;
         rd_start_q <= 1'b0;
         status_q   <= '0;
         resp_idx_q <= '0;
         resp_arg_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         done_q     <= done_d;
         rd_start_q <= rd_start_d;
         status_q   <= status_d;
         resp_idx_q <= resp_idx_d;
         resp_arg_q <= resp_arg_d;
      end
   end

   // Frame shifters and latched command flags are only meaningful while
   // the state machine is past IDLE, so they carry no reset
   always_ff @(posedge clk) begin
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      resp_en_q  <= resp_en_d;
      crc_chk_q  <= crc_chk_d;
      data_exp_q <= data_exp_d;
   end

   assign bus.o_cmd_out    = cmd_out;
   assign bus.o_cmd_oe     = cmd_oe;
   assign bus.o_busy       = (state_q != CMD_IDLE);
   assign bus.o_done       = done_q;
   assign bus.o_rd_start   = rd_start_q;
   assign bus.o_status     = status_q;
   assign bus.o_resp_index = resp_idx_q;
   assign bus.o_resp_arg   = resp_arg_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sd_cmd_ctrl
// Directed stimulus with scoreboard queues. The driver pushes the expected
// CMD frame, completion and reader-start events; independent monitors pop
// and compare whenever the controller drives CMD, pulses o_done or pulses
// o_rd_start. Cycle n is counted from the cycle in which the strobe is held
// (cycle 0); everything is sampled on the falling edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sd_cmd_ctrl;
   import sd_pkg::*;

   localparam int RT = 64;
   localparam int NC = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_at_edge = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc         <= cyc + 1;
      rst_at_edge <= rst;
   end

   sd_cmd_ctrl_if bus();

   sd_cmd_ctrl #(.RESP_TIMEOUT(RT), .NCC(NC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [47:0] frame;
      int          base;
   } tx_exp_t;

   typedef struct {
      int          base;
      int          rel;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [2:0]  st;
      bit          chk_resp;
   } done_exp_t;

   tx_exp_t   tx_q[$];
   done_exp_t dn_q[$];
   int        rd_q[$];

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference CRC7 used only for the CMD17 frames; the other frames are
   // fixed constants
   function automatic logic [6:0] ref_crc7(input logic [39:0] d);
      logic [6:0] c;
      logic       fb;
      c = '0;
      for (int i = 39; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] full_frame(input logic [7:0] b0, input logic [31:0] arg);
      logic [39:0] body;
      body = {b0, arg};
      return {body, ref_crc7(body), 1'b1};
   endfunction

   // ---------------- monitors ----------------
   logic [47:0] cap = '0;
   int          nbits = 0;
   done_exp_t   dcur;
   int          rbase;

   always @(negedge clk) begin
      if (bus.o_cmd_oe) begin
         if (nbits == 0) begin
            if (tx_q.size() == 0) check("tx_unexpected_frame", 1, 0);
            else                  check("tx_first_cycle", cyc - tx_q[0].base, 1);
         end
         cap = {cap[46:0], bus.o_cmd_out};
         nbits++;
         if (nbits == 48) begin
            if (tx_q.size() != 0) begin
               check("tx_frame", cap, tx_q[0].frame);
               void'(tx_q.pop_front());
            end
            nbits = 0;
         end
      end else begin
         check("idle_line_high", bus.o_cmd_out, 1);
         if (nbits != 0) begin
            if (!rst_at_edge) check("tx_frame_length", nbits, 48);
            if (tx_q.size() != 0) void'(tx_q.pop_front());
            nbits = 0;
         end
      end

      if (bus.o_done) begin
         if (dn_q.size() == 0) begin
            check("done_unexpected", 1, 0);
         end else begin
            dcur = dn_q.pop_front();
            check("done_cycle", cyc - dcur.base, dcur.rel);
            check("status", bus.o_status, dcur.st);
            if (dcur.chk_resp) begin
               check("resp_index", bus.o_resp_index, dcur.idx);
               check("resp_arg", bus.o_resp_arg, dcur.arg);
            end
         end
      end

      if (bus.o_rd_start) begin
         if (rd_q.size() == 0) begin
            check("rd_start_unexpected", 1, 0);
         end else begin
            rbase = rd_q.pop_front();
            check("rd_start_cycle", cyc - rbase, 49);
         end
      end
   end

   // ---------------- driver tasks (called on a falling edge) ----------------
   task automatic wait_idle();
      int n = 0;
      while (bus.o_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) check("busy_release_timeout", 1, 0);
   endtask

   task automatic wait_rel(input int base, input int rel);
      while (cyc - base < rel) @(negedge clk);
   endtask

   task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                        input bit re, input bit cc, input bit de,
                        input logic [47:0] frame, output int base);
      tx_exp_t t;
      wait_idle();
      base          = cyc;
      t.frame       = frame;
      t.base        = base;
      tx_q.push_back(t);
      bus.i_cmd_index = idx;
      bus.i_cmd_arg   = arg;
      bus.i_resp_en   = re;
      bus.i_crc_chk   = cc;
      bus.i_data_exp  = de;
      bus.i_cmd_start = 1'b1;
      @(negedge clk);
      bus.i_cmd_start = 1'b0;
   endtask

   task automatic expect_done(input int base, input int rel, input logic [5:0] idx,
                              input logic [31:0] arg, input logic [2:0] st, input bit chk);
      done_exp_t d;
      d.base = base; d.rel = rel; d.idx = idx; d.arg = arg; d.st = st; d.chk_resp = chk;
      dn_q.push_back(d);
   endtask

   // Card model: drives a 48-bit response starting at cycle base+start
   task automatic reply(input int base, input logic [47:0] frame, input int start);
      wait_rel(base, start);
      for (int i = 47; i >= 0; i--) begin
         bus.i_cmd_in = frame[i];
         @(negedge clk);
      end
      bus.i_cmd_in = 1'b1;
   endtask

   task automatic poke(input logic [5:0] idx);
      bus.i_cmd_index = idx;
      bus.i_cmd_start = 1'b1;
      @(negedge clk);
      bus.i_cmd_start = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int b;
      logic [47:0] f17, r17;

      bus.i_cmd_start = 1'b0;
      bus.i_cmd_index = '0;
      bus.i_cmd_arg   = '0;
      bus.i_resp_en   = 1'b0;
      bus.i_crc_chk   = 1'b0;
      bus.i_data_exp  = 1'b0;
      bus.i_cmd_in    = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_oe", bus.o_cmd_oe, 0);
      check("rst_out", bus.o_cmd_out, 1);
      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_rd_start", bus.o_rd_start, 0);
      check("rst_status", bus.o_status, 0);
      check("rst_resp_index", bus.o_resp_index, 0);
      check("rst_resp_arg", bus.o_resp_arg, 0);
      rst = 1'b0;
      @(negedge clk);

      // CMD0, no response
      issue(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 48'h400000000095, b);
      expect_done(b, 49, 6'd0, 32'h0, 3'b000, 1'b0);
      wait_rel(b, 50);
      wait_idle();

      // CMD8 with a clean R7
      issue(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, b);
      expect_done(b, 99, 6'd8, 32'h1AA, 3'b000, 1'b1);
      reply(b, 48'h08000001AA13, 51);
      wait_idle();

      // Response CRC bit flipped, CRC checked
      issue(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, b);
      expect_done(b, 99, 6'd8, 32'h1AA, 3'b010, 1'b1);
      reply(b, 48'h08000001AA11, 51);
      wait_idle();

      // Same corrupted response, CRC not checked
      issue(6'd8, 32'h1AA, 1'b1, 1'b0, 1'b0, 48'h48000001AA87, b);
      expect_done(b, 99, 6'd8, 32'h1AA, 3'b000, 1'b1);
      reply(b, 48'h08000001AA11, 51);
      wait_idle();

      // End bit 0 in the response
      issue(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, b);
      expect_done(b, 99, 6'd8, 32'h1AA, 3'b100, 1'b1);
      reply(b, 48'h08000001AA12, 51);
      wait_idle();

      // No response: timeout, then the NCC gap
      issue(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, b);
      expect_done(b, 113, 6'd0, 32'h0, 3'b001, 1'b0);
      wait_rel(b, 120);
      check("timeout_busy_120", bus.o_busy, 1);
      wait_rel(b, 121);
      check("timeout_busy_121", bus.o_busy, 0);

      // CMD17 opening a read phase, with strobes during busy and on o_done
      f17 = full_frame(8'h51, 32'h200);
      r17 = full_frame(8'h11, 32'h900);
      issue(6'd17, 32'h200, 1'b1, 1'b1, 1'b1, f17, b);
      rd_q.push_back(b);
      expect_done(b, 99, 6'd17, 32'h900, 3'b000, 1'b1);
      wait_rel(b, 10);
      poke(6'd55);
      reply(b, r17, 51);
      check("cmd17_poke_on_done_cycle", cyc - b, 99);
      poke(6'd55);
      bus.i_data_exp = 1'b0;
      wait_idle();
      check("cmd17_idle_after_gap", bus.o_cmd_oe, 0);

      // Reset in the middle of SEND
      issue(6'd8, 32'h1AA, 1'b1, 1'b1, 1'b0, 48'h48000001AA87, b);
      wait_rel(b, 20);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_oe", bus.o_cmd_oe, 0);
      check("midrst_out", bus.o_cmd_out, 1);
      check("midrst_busy", bus.o_busy, 0);
      check("midrst_done", bus.o_done, 0);
      repeat (60) @(negedge clk);

      // Normal command after the reset
      issue(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 48'h400000000095, b);
      expect_done(b, 49, 6'd0, 32'h0, 3'b000, 1'b0);
      wait_rel(b, 50);
      wait_idle();
      repeat (5) @(negedge clk);

      check("tx_queue_empty", tx_q.size(), 0);
      check("done_queue_empty", dn_q.size(), 0);
      check("rd_queue_empty", rd_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
